// File: rtl/led_pattern_engine_if.sv
// ---------------------------------------------------------------------------
// led_pattern_engine_if
// Bundles the status/mode/hold inputs and the LED/busy/wrap outputs of the
// LED pattern engine. The controller side uses the master modport. The engine
// side uses the slave modport.
// ---------------------------------------------------------------------------
interface led_pattern_engine_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       sta;    // status code from the controller
    logic [1:0]       mode;   // 0 breathe, 1 chase, 2 blink, 3 bounce
    logic             hold;   // freezes the running pattern while high
    logic [WIDTH-1:0] led;    // LED drive, bit WIDTH-1 is leftmost
    logic             busy;   // display active
    logic             wrap;   // one-cycle pulse at the end of a pattern period

    modport master (
        output sta, mode, hold,
        input  led, busy, wrap
    );

    modport slave (
        input  sta, mode, hold,
        output led, busy, wrap
    );
endinterface

// File: rtl/led_pattern_engine.sv
// ---------------------------------------------------------------------------
// led_pattern_engine
// Drives a row of WIDTH LEDs with one of four animated patterns while the
// controller status code is one of the alarm codes. A prescaler divides clk
// down to one pattern step every DIV cycles. The display is blanked and
// restarted whenever it goes inactive or the pattern selection changes.
//
// Priority on each edge: inactive > mode change > hold > tick.
// ---------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int          WIDTH      = 16,          // LED count, even, >= 4
    parameter int          DIV        = 25000000,    // clk cycles per step, >= 1
    parameter logic [15:0] ALARM_MASK = 16'h01C0     // status codes that light the display
) (
    input  logic               clk,
    input  logic               rst_n,
    led_pattern_engine_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_BREATHE = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BOUNCE  = 2'd3
    } mode_e;

    // The longest period (bounce) is 2*WIDTH-2 steps.
    localparam int SW = $clog2(2 * WIDTH - 2);
    // A one-cycle prescaler still needs one bit to exist.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] LED_ONE   = WIDTH'(1);
    localparam int               HALF      = WIDTH / 2;

    // -----------------------------------------------------------------------
    // Pattern lookup: LED image for a given pattern and step index.
    // Shifts are used instead of variable bit selects to keep the index
    // arithmetic in plain integers.
    // -----------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] pattern(input mode_e m, input logic [SW-1:0] k);
        logic [WIDTH-1:0] v;
        int               kk;
        int               n;
        v  = '0;
        kk = int'(k);
        n  = 0;
        case (m)
            MODE_BREATHE: begin
                // n = number of lit bits on each side of the centre line.
                if (kk < HALF)
                    n = kk + 1;
                else if (kk <= WIDTH - 2)
                    n = WIDTH - 1 - kk;
                else
                    n = 0;
                // 2n contiguous ones, shifted so they straddle the centre.
                v = ((LED_ONE << (2 * n)) - LED_ONE) << (HALF - n);
            end
            MODE_CHASE: begin
                if (kk < WIDTH)
                    v = LED_ONE << (WIDTH - 1 - kk);
            end
            MODE_BLINK: begin
                v = (kk == 0) ? '1 : '0;
            end
            MODE_BOUNCE: begin
                // Sweep left-to-right, then come back without repeating the ends.
                if (kk < WIDTH)
                    v = LED_ONE << (WIDTH - 1 - kk);
                else if (kk < 2 * WIDTH - 2)
                    v = LED_ONE << (kk - WIDTH + 1);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Last step index of each pattern, i.e. period minus one.
    function automatic logic [SW-1:0] last_step(input mode_e m);
        logic [SW-1:0] s;
        case (m)
            MODE_BREATHE: s = SW'(WIDTH - 1);
            MODE_CHASE:   s = SW'(WIDTH - 1);
            MODE_BLINK:   s = SW'(1);
            MODE_BOUNCE:  s = SW'(2 * WIDTH - 3);
            default:      s = '0;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             r_active;
    mode_e            r_mode;
    logic [SW-1:0]    r_step;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_led;
    logic             r_wrap;

    logic             w_tick;
    logic             w_last;
    logic             w_mode_change;
    logic [WIDTH-1:0] w_pattern;

    assign w_tick        = (r_presc == PRESC_MAX);
    assign w_last        = (r_step >= last_step(r_mode));
    assign w_mode_change = (bus.mode != r_mode);
    assign w_pattern     = pattern(r_mode, r_step);

    // Register the activity flag, mode, prescaler, step and LED image.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values. Blocking assignments would let later lines see
    // already-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_mode   <= MODE_BREATHE;
            r_step   <= '0;
            r_presc  <= '0;
            r_led    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_active <= ALARM_MASK[bus.sta];
            r_mode   <= mode_e'(bus.mode);
            r_wrap   <= 1'b0;

            if (!r_active) begin
                // Display off: abandon any pattern in progress.
                r_led   <= '0;
                r_step  <= '0;
                r_presc <= '0;
            end else if (w_mode_change) begin
                // New pattern starts from step 0 after a full prescaler period.
                r_led   <= '0;
                r_step  <= '0;
                r_presc <= '0;
            end else if (bus.hold) begin
                // Frozen: prescaler, step and LEDs keep their values.
            end else if (w_tick) begin
                r_led   <= w_pattern;
                r_presc <= '0;
                r_wrap  <= w_last;
                r_step  <= w_last ? '0 : r_step + SW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_active;
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_engine
// Directed bench for led_pattern_engine with WIDTH=16. One instance runs with
// DIV=4 for the breathe, inactive, hold/mode and reset scenarios. A second
// instance runs with DIV=1 for bounce. Inputs change and outputs are sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_led_pattern_engine;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    led_pattern_engine_if #(.WIDTH(W)) bus4 ();
    led_pattern_engine_if #(.WIDTH(W)) bus1 ();

    led_pattern_engine #(.WIDTH(W), .DIV(4), .ALARM_MASK(16'h01C0)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    led_pattern_engine #(.WIDTH(W), .DIV(1), .ALARM_MASK(16'h01C0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Hand-computed breathe sequence for WIDTH=16.
    logic [15:0] breathe_exp [16] = '{
        16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hFFFF,
        16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0180, 16'h0000
    };

    task automatic apply_reset();
        rst_n     = 1'b0;
        bus4.sta  = 4'd0; bus4.mode = 2'd0; bus4.hold = 1'b0;
        bus1.sta  = 4'd0; bus1.mode = 2'd0; bus1.hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus4.sta = 4'd6; bus4.mode = 2'd0; bus4.hold = 1'b0;
        bus1.sta = 4'd8; bus1.mode = 2'd3; bus1.hold = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL reset_led4: got %h want 0000", bus4.led); end
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy4: got %b want 0", bus4.busy); end
        total++; if (bus4.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap4: got %b want 0", bus4.wrap); end
        total++; if (bus1.led !== 16'h0000) begin bad++; $display("FAIL reset_led1: got %h want 0000", bus1.led); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", bus1.busy); end
        total++; if (bus1.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap1: got %b want 0", bus1.wrap); end
    endtask

    task automatic test_breathe();
        logic [15:0] prev;
        logic [15:0] exp;
        logic        exp_wrap;
        apply_reset();
        bus4.sta = 4'd6; bus4.mode = 2'd0;
        @(negedge clk);
        total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL breathe_busy: got %b want 1", bus4.busy); end
        total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL breathe_led_pre: got %h want 0000", bus4.led); end
        prev = 16'h0000;
        // One full period plus the first step of the next one.
        for (int k = 0; k < 17; k++) begin
            repeat (3) begin
                @(negedge clk);
                total++; if (bus4.led !== prev || bus4.wrap !== 1'b0) begin
                    bad++; $display("FAIL breathe_between k=%0d: got led=%h wrap=%b want led=%h wrap=0", k, bus4.led, bus4.wrap, prev);
                end
            end
            @(negedge clk);
            exp      = breathe_exp[k % 16];
            exp_wrap = (k == 15);
            total++; if (bus4.led !== exp) begin bad++; $display("FAIL breathe_led k=%0d: got %h want %h", k, bus4.led, exp); end
            total++; if (bus4.wrap !== exp_wrap) begin bad++; $display("FAIL breathe_wrap k=%0d: got %b want %b", k, bus4.wrap, exp_wrap); end
            prev = exp;
        end
    endtask

    task automatic test_inactive();
        apply_reset();
        bus4.sta = 4'd5; bus4.mode = 2'd0;
        repeat (20) begin
            @(negedge clk);
            total++; if ({bus4.busy, bus4.wrap, bus4.led} !== 18'd0) begin
                bad++; $display("FAIL inactive_idle: got busy=%b wrap=%b led=%h want all 0", bus4.busy, bus4.wrap, bus4.led);
            end
        end
        bus4.sta = 4'd7;
        @(negedge clk);
        total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL inactive_act_busy: got %b want 1", bus4.busy); end
        repeat (4) @(negedge clk);
        total++; if (bus4.led !== 16'h0180) begin bad++; $display("FAIL inactive_step0: got %h want 0180", bus4.led); end
        repeat (4) @(negedge clk);
        total++; if (bus4.led !== 16'h03C0) begin bad++; $display("FAIL inactive_step1: got %h want 03C0", bus4.led); end
        bus4.sta = 4'd3;
        @(negedge clk);
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL inactive_fall_busy: got %b want 0", bus4.busy); end
        total++; if (bus4.led !== 16'h03C0) begin bad++; $display("FAIL inactive_fall_led_hold: got %h want 03C0", bus4.led); end
        @(negedge clk);
        total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL inactive_fall_led: got %h want 0000", bus4.led); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h0000 || bus4.busy !== 1'b0) begin
                bad++; $display("FAIL inactive_off: got led=%h busy=%b want 0000/0", bus4.led, bus4.busy);
            end
        end
        bus4.sta = 4'd7;
        @(negedge clk);
        total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL inactive_react_busy: got %b want 1", bus4.busy); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL inactive_react_wait: got %h want 0000", bus4.led); end
        end
        @(negedge clk);
        total++; if (bus4.led !== 16'h0180) begin bad++; $display("FAIL inactive_restart: got %h want 0180", bus4.led); end
    endtask

    task automatic test_bounce();
        logic [15:0] one;
        logic [15:0] exp;
        logic        exp_wrap;
        int          kk;
        one = 16'h0001;
        apply_reset();
        bus1.sta = 4'd8; bus1.mode = 2'd3;
        @(negedge clk);
        total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL bounce_busy: got %b want 1", bus1.busy); end
        total++; if (bus1.led !== 16'h0000) begin bad++; $display("FAIL bounce_led_pre: got %h want 0000", bus1.led); end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            kk       = k % 30;
            exp      = (kk < 16) ? (one << (15 - kk)) : (one << (kk - 15));
            exp_wrap = (k == 29);
            total++; if (bus1.led !== exp) begin bad++; $display("FAIL bounce_led k=%0d: got %h want %h", k, bus1.led, exp); end
            total++; if (bus1.wrap !== exp_wrap) begin bad++; $display("FAIL bounce_wrap k=%0d: got %b want %b", k, bus1.wrap, exp_wrap); end
        end
        bus1.sta = 4'd0;
    endtask

    task automatic test_hold_mode();
        apply_reset();
        bus4.sta = 4'd6; bus4.mode = 2'd1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        total++; if (bus4.led !== 16'h8000) begin bad++; $display("FAIL chase_step0: got %h want 8000", bus4.led); end
        repeat (4) @(negedge clk);
        total++; if (bus4.led !== 16'h4000) begin bad++; $display("FAIL chase_step1: got %h want 4000", bus4.led); end
        // Short hold: the prescaler must not advance while held.
        bus4.hold = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h4000) begin bad++; $display("FAIL short_hold: got %h want 4000", bus4.led); end
        end
        bus4.hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h4000) begin bad++; $display("FAIL hold_resume_wait: got %h want 4000", bus4.led); end
        end
        @(negedge clk);
        total++; if (bus4.led !== 16'h2000) begin bad++; $display("FAIL chase_step2: got %h want 2000", bus4.led); end
        bus4.hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h2000 || bus4.wrap !== 1'b0) begin
                bad++; $display("FAIL long_hold: got led=%h wrap=%b want 2000/0", bus4.led, bus4.wrap);
            end
        end
        bus4.hold = 1'b0; bus4.mode = 2'd2;
        @(negedge clk);
        total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL mode_change_clear: got %h want 0000", bus4.led); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL blink_wait: got %h want 0000", bus4.led); end
        end
        @(negedge clk);
        total++; if (bus4.led !== 16'hFFFF || bus4.wrap !== 1'b0) begin
            bad++; $display("FAIL blink_on0: got led=%h wrap=%b want FFFF/0", bus4.led, bus4.wrap);
        end
        repeat (4) @(negedge clk);
        total++; if (bus4.led !== 16'h0000 || bus4.wrap !== 1'b1) begin
            bad++; $display("FAIL blink_off: got led=%h wrap=%b want 0000/1", bus4.led, bus4.wrap);
        end
        @(negedge clk);
        total++; if (bus4.wrap !== 1'b0) begin bad++; $display("FAIL blink_wrap_width: got %b want 0", bus4.wrap); end
        repeat (3) @(negedge clk);
        total++; if (bus4.led !== 16'hFFFF || bus4.wrap !== 1'b0) begin
            bad++; $display("FAIL blink_on1: got led=%h wrap=%b want FFFF/0", bus4.led, bus4.wrap);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus4.sta = 4'd6; bus4.mode = 2'd0;
        @(negedge clk);
        repeat (16) @(negedge clk);
        total++; if (bus4.led !== 16'h0FF0) begin bad++; $display("FAIL reset_mid_pre: got %h want 0FF0", bus4.led); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL reset_mid_led: got %h want 0000", bus4.led); end
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", bus4.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy_after: got %b want 1", bus4.busy); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus4.led !== 16'h0000) begin bad++; $display("FAIL reset_mid_wait: got %h want 0000", bus4.led); end
        end
        @(negedge clk);
        total++; if (bus4.led !== 16'h0180) begin bad++; $display("FAIL reset_mid_first: got %h want 0180", bus4.led); end
    endtask

    initial begin
        test_reset();
        test_breathe();
        test_inactive();
        test_bounce();
        test_hold_mode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
